// File: rtl/iecdrv_rom_loader.sv
// Fetches drive ROM bytes from shared system memory on behalf of the IEC drive selector.
// One read is in flight at a time; a stalled memory port times out and returns 8'hFF.
module iecdrv_rom_loader #(
  parameter logic [24:0] BASE_ADDR = 25'h0F00000,
  parameter int          TIMEOUT   = 255,
  parameter int          SETTLE    = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        rom_req,
  input  logic [18:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_wr,
  output logic        mem_rd,
  output logic [24:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_din,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_SETTLE
  } state_t;

  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);
  localparam logic [2:0] SETTLE_END = 3'(SETTLE);

  state_t     state;
  state_t     state_nxt;
  logic [9:0] tmo_cnt;
  logic [2:0] settle_cnt;
  logic       tmo_hit;
  logic       settle_done;
  logic       latch_addr;

  function automatic logic [24:0] rom_to_mem(input logic [18:0] a);
    return BASE_ADDR + {6'd0, a};
  endfunction

  always_comb begin
    state_nxt   = state;
    latch_addr  = 1'b0;
    tmo_hit     = (tmo_cnt == TMO_LAST);
    settle_done = (settle_cnt == SETTLE_END);
    case (state)
      S_IDLE: begin
        if (rom_req) begin
          state_nxt  = S_ISSUE;
          latch_addr = 1'b1;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      // An ack in the last counted cycle takes priority over the timeout.
      S_WAIT: begin
        if (mem_ack || tmo_hit) state_nxt = S_WRITE;
      end
      S_WRITE: state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (settle_done) begin
          if (rom_req) begin
            state_nxt  = S_ISSUE;
            latch_addr = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      mem_addr   <= '0;
      rom_data   <= '0;
      err        <= 1'b0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (latch_addr) mem_addr <= rom_to_mem(rom_addr);
      case (state)
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          if (mem_ack) begin
            rom_data <= mem_din;
          end else if (tmo_hit) begin
            rom_data <= 8'hFF;
            err      <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        S_WRITE: settle_cnt <= '0;
        // Holds at SETTLE_END for the decision cycle, giving SETTLE+1 cycles in this state.
        S_SETTLE: begin
          if (!settle_done) settle_cnt <= settle_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_rd = (state == S_ISSUE);
  assign rom_wr = (state == S_WRITE);
  assign busy   = (state != S_IDLE);

endmodule
